prbs_checker: RTL and testbench
===============================

# prbs_checker

Serial receive-side checker for the LFSR pattern generator. It takes one bit per valid cycle from the generator's feedback stream and self-synchronises a local N-bit LFSR to it. Once locked, it free-runs that LFSR to predict each incoming bit, then flags and counts mismatches. It sits at the far end of a link or loopback path and provides bit-error statistics for link bring-up and BIST.

## Interface
- N, 4: LFSR width. Supported range is 2..8; any other value is an elaboration error. Taps are identical to the generator's.
- LOCK_CNT, 8: consecutive correct predictions required in VERIFY before LOCKED (≥1).
- LOSS_THRESH, 4: consecutive mismatches in LOCKED that force a return to SYNC (≥1).
- CNT_W, 16: width of the saturating counters.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- rx_valid  in  1  rx_bit is valid this cycle; all state advances only on valid cycles
- rx_bit  in  1  received serial bit (generator's feedback bit, one per cycle)
- clear_counts  in  1  synchronous clear of err_count and bit_count
- locked  out  1  checker is in LOCKED state
- err_pulse  out  1  one-cycle pulse: mismatch detected while LOCKED
- err_count  out  CNT_W  saturating count of mismatches while LOCKED
- bit_count  out  CNT_W  saturating count of valid bits checked while LOCKED

## Operation
- Stream model: the generator shifts left each cycle, and the new bit0 equals fb(state). The transmitted bit is fb(state).
- Feedback fb(r) per N:
  - N=2: r1^r0
  - N=3: r2^r1
  - N=4: r3^r2
  - N=5: r4^r2
  - N=6: r5^r4
  - N=7: r6^r5
  - N=8: r7^r5^r4^r3
- Prediction each valid cycle: p = fb(shift_reg).
- SYNC:
  - Each valid bit: shift_reg <= {shift_reg[N-2:0], rx_bit}; fill_cnt++.
  - When the N-th bit is shifted in: if the resulting register is nonzero, go to VERIFY with match_cnt=0. If it is all-zero, clear fill_cnt and stay in SYNC.
- VERIFY (self-sync):
  - Each valid bit: compare rx_bit with p, then shift in rx_bit.
  - On a match, match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED with consec=0.
  - On a mismatch, go to SYNC with fill_cnt=0. shift_reg keeps the shifted value.
- LOCKED (free-run):
  - Each valid bit: shift in p (not rx_bit), so a single bit error counts exactly once.
  - bit_count++ on every valid bit.
  - On mismatch: err_pulse=1, err_count++, consec++. On match: consec=0.
  - When consec reaches LOSS_THRESH: go to SYNC with fill_cnt=0. That last errored bit is still counted.
- Counters saturate at all-ones and never wrap.
- clear_counts has priority over increments in the same cycle: both counters become 0. err_pulse still fires for a concurrent error.
- rx_valid=0: no state, register or counter change, and err_pulse=0.

## Timing
- All outputs are registered. Reset values:
  - locked=0, err_pulse=0, err_count=0, bit_count=0
  - state=SYNC, shift_reg=0
  - fill_cnt, match_cnt and consec all 0
- err_pulse asserts the cycle after the errored bit is sampled and lasts one cycle per errored bit. Back-to-back errors produce a continuously high err_pulse.
- locked rises the cycle after the LOCK_CNT-th matching bit is sampled.
- locked falls the cycle after the LOSS_THRESH-th consecutive error is sampled.
- Minimum lock latency from reset release with continuous valid data: N + LOCK_CNT valid bits.
- Counters update in the same cycle as err_pulse.
- Asynchronous reset mid-operation returns every register to its reset value immediately. Re-acquisition starts from SYNC.

## Structure
- Package prbs_pkg:
  - state enum: SYNC, VERIFY, LOCKED
  - function lfsr_fb(logic [7:0] r, int n) implementing the tap list above; shared with the generator so the tap sets cannot diverge.
- Optional sub-module prbs_err_counter: saturating CNT_W counter with clear priority, instantiated twice. Everything else is a single FSM plus datapath in prbs_checker.

## Test plan
- N=4, LOCK_CNT=8, generator seeded with 4'b1001, continuous valid; stream begins 1,0,1,0,1,1,… -> locked rises after the 12th bit; err_count stays 0; bit_count increments once per bit afterwards.
- Locked, invert one bit -> exactly one err_pulse; err_count=1; locked stays 1; following bits match again.
- Locked, LOSS_THRESH=4, invert 4 consecutive bits -> 4 err_pulses, err_count=4, locked falls; clean stream re-locks after N+LOCK_CNT=12 bits.
- Feed all-zero bits -> checker never leaves SYNC; locked=0; counters stay 0.
- rx_valid toggled 1,0,1,0 during lock acquisition -> lock occurs after 12 valid bits, not 12 cycles; invalid cycles change nothing.
- Force err_count to saturation (CNT_W=4: 15 errors, with LOSS_THRESH large) -> stays at 15 after further errors. clear_counts asserted coincident with an error -> both counters 0 and err_pulse=1. Reset asserted mid-lock -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the LFSR pattern generator and the prbs_checker.
//   state_e  : checker FSM states (SYNC, VERIFY, LOCKED)
//   lfsr_fb  : feedback bit of an n-bit LFSR. The generator imports the same
//              function, so both ends of the link always agree on the taps.
// ---------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // r[0] is the most recently shifted-in bit; r[n-1] the oldest.
    function automatic logic lfsr_fb(logic [7:0] r, int n);
        logic fb;
        fb = 1'b0;
        case (n)
            2:       fb = r[1] ^ r[0];
            3:       fb = r[2] ^ r[1];
            4:       fb = r[3] ^ r[2];
            5:       fb = r[4] ^ r[2];
            6:       fb = r[5] ^ r[4];
            7:       fb = r[6] ^ r[5];
            8:       fb = r[7] ^ r[5] ^ r[4] ^ r[3];
            default: fb = 1'b0;
        endcase
        return fb;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// ---------------------------------------------------------------------------
// prbs_checker_if
// Receive stream and statistics bundle of the prbs_checker.
//   rx_valid, rx_bit, clear_counts : source -> checker
//   locked, err_pulse              : checker status
//   err_count, bit_count           : saturating CNT_W-bit statistics
// Modports: master (stream source / statistics reader), slave (checker).
// ---------------------------------------------------------------------------
interface prbs_checker_if #(
    parameter int CNT_W = 16
) ();

    logic             rx_valid;
    logic             rx_bit;
    logic             clear_counts;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output rx_valid, rx_bit, clear_counts,
        input  locked, err_pulse, err_count, bit_count
    );

    modport slave (
        input  rx_valid, rx_bit, clear_counts,
        output locked, err_pulse, err_count, bit_count
    );

endinterface

// File: rtl/prbs_err_counter.sv
// ---------------------------------------------------------------------------
// prbs_err_counter
// Saturating up-counter; a clear wins over an increment in the same cycle.
//   clk, reset : clock, asynchronous active-low reset
//   clear_i    : synchronous clear to zero
//   inc_i      : increment by one, holding at all-ones
//   count_o    : registered count
// ---------------------------------------------------------------------------
module prbs_err_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
// Self-synchronising receive-side PRBS checker. SYNC fills an N-bit shift
// register from the line, VERIFY confirms LOCK_CNT consecutive predictions,
// LOCKED free-runs the local LFSR and counts bit errors; LOSS_THRESH
// consecutive errors drop back to SYNC.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : prbs_checker_if slave (rx_valid, rx_bit, clear_counts in;
//                locked, err_pulse, err_count, bit_count out, all registered)
// ---------------------------------------------------------------------------
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N           = 4,
    parameter int LOCK_CNT    = 8,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           reset,
    prbs_checker_if.slave  bus
);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("prbs_checker: N must be in the range 2..8");
    end
    if (LOCK_CNT < 1 || LOSS_THRESH < 1) begin : g_bad_cnt
        $error("prbs_checker: LOCK_CNT and LOSS_THRESH must be at least 1");
    end

    localparam int FILL_W   = $clog2(N + 1);
    localparam int MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam int CONSEC_W = $clog2(LOSS_THRESH + 1);

    state_e              state_q, state_d;
    logic [N-1:0]        shift_q, shift_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic                locked_q;
    logic                err_pulse_q, err_pulse_d;
    logic                bit_inc, err_inc;
    logic                predict, mismatch;

    assign predict  = lfsr_fb(8'(shift_q), N);
    assign mismatch = bus.rx_bit != predict;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        fill_d      = fill_q;
        match_d     = match_q;
        consec_d    = consec_q;
        err_pulse_d = 1'b0;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;

        if (bus.rx_valid) begin
            unique case (state_q)
                SYNC: begin
                    shift_d = {shift_q[N-2:0], bus.rx_bit};
                    if (fill_q == FILL_W'(N - 1)) begin
                        fill_d = '0;
                        // An all-zero register is the LFSR lock-up state: refill.
                        if (|shift_d) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end

                VERIFY: begin
                    shift_d = {shift_q[N-2:0], bus.rx_bit};
                    if (mismatch) begin
                        state_d = SYNC;
                        fill_d  = '0;
                    end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                        state_d  = LOCKED;
                        consec_d = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end

                LOCKED: begin
                    // Free-run on the prediction so one line error counts once.
                    shift_d = {shift_q[N-2:0], predict};
                    bit_inc = 1'b1;
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        if (consec_q == CONSEC_W'(LOSS_THRESH - 1)) begin
                            state_d = SYNC;
                            fill_d  = '0;
                        end else begin
                            consec_d = consec_q + CONSEC_W'(1);
                        end
                    end else begin
                        consec_d = '0;
                    end
                end

                default: begin
                    state_d = SYNC;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SYNC;
            shift_q     <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            consec_q    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            consec_q    <= consec_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_pulse_d;
        end
    end

    prbs_err_counter #(.CNT_W(CNT_W)) u_err_count (
        .clk     (clk),
        .reset   (reset),
        .clear_i (bus.clear_counts),
        .inc_i   (err_inc),
        .count_o (bus.err_count)
    );

    prbs_err_counter #(.CNT_W(CNT_W)) u_bit_count (
        .clk     (clk),
        .reset   (reset),
        .clear_i (bus.clear_counts),
        .inc_i   (bit_inc),
        .count_o (bus.bit_count)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
// Scoreboard bench for prbs_checker (N=4, LOCK_CNT=8, LOSS_THRESH=4, CNT_W=4).
// The driver applies one input set per cycle, steps a behavioural model and
// queues the expected registered outputs; the monitor pops one entry after
// each rising edge and compares all four outputs.
// ---------------------------------------------------------------------------
module tb_prbs_checker;

    localparam int N           = 4;
    localparam int LOCK_CNT    = 8;
    localparam int LOSS_THRESH = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct {
        bit locked;
        bit pulse;
        int errc;
        int bitc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    exp_t sb_q[$];

    prbs_checker_if #(.CNT_W(CNT_W)) ifc ();

    prbs_checker #(
        .N           (N),
        .LOCK_CNT    (LOCK_CNT),
        .LOSS_THRESH (LOSS_THRESH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- generator: x^4 + x^3 + 1 recurrence -----------------
    // Line bit t equals bit(t-4) xor bit(t-3). Seed 4'b1001 is the history
    // 1,0,0,1 (oldest first), giving the stream 1,0,1,0,1,1,...
    bit gen_hist[$];

    function automatic bit gen_next();
        bit b;
        b = gen_hist[0] ^ gen_hist[1];
        void'(gen_hist.pop_front());
        gen_hist.push_back(b);
        return b;
    endfunction

    // ---------------- behavioural checker model ----------------------------
    // m_win holds the last N values fed into the local LFSR, oldest first;
    // the prediction is the same recurrence applied to that window.
    int m_mode;   // 0 = acquiring fill, 1 = verifying, 2 = locked
    int m_fill, m_match, m_consec;
    int m_err, m_bits;
    bit m_pulse;
    bit m_win[$];

    function automatic void model_reset();
        m_mode = 0; m_fill = 0; m_match = 0; m_consec = 0;
        m_err = 0; m_bits = 0; m_pulse = 0;
        m_win = {1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic void win_push(input bit b);
        void'(m_win.pop_front());
        m_win.push_back(b);
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit clr);
        bit p;
        bit mis;
        m_pulse = 0;
        if (v) begin
            p   = m_win[0] ^ m_win[1];
            mis = (b != p);
            if (m_mode == 0) begin
                win_push(b);
                m_fill++;
                if (m_fill == N) begin
                    m_fill = 0;
                    if (m_win[0] | m_win[1] | m_win[2] | m_win[3]) begin
                        m_mode  = 1;
                        m_match = 0;
                    end
                end
            end else if (m_mode == 1) begin
                win_push(b);
                if (mis) begin
                    m_mode = 0;
                    m_fill = 0;
                end else begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_mode   = 2;
                        m_consec = 0;
                    end
                end
            end else begin
                win_push(p);
                if (m_bits < CNT_MAX) m_bits++;
                if (mis) begin
                    m_pulse = 1;
                    if (m_err < CNT_MAX) m_err++;
                    m_consec++;
                    if (m_consec == LOSS_THRESH) begin
                        m_mode = 0;
                        m_fill = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
        end
        if (clr) begin
            m_err  = 0;
            m_bits = 0;
        end
    endfunction

    // ---------------- driver helpers ---------------------------------------
    task automatic drive(input bit v, input bit b, input bit clr);
        exp_t e;
        @(negedge clk);
        ifc.rx_valid     = v;
        ifc.rx_bit       = b;
        ifc.clear_counts = clr;
        model_step(v, b, clr);
        e.locked = (m_mode == 2);
        e.pulse  = m_pulse;
        e.errc   = m_err;
        e.bitc   = m_bits;
        sb_q.push_back(e);
    endtask

    task automatic send_gen(input bit inv, input bit clr);
        bit b;
        b = gen_next();
        drive(1'b1, b ^ inv, clr);
    endtask

    // Sends clean stream bits until locked is seen; returns the number of
    // valid bits it took, or -1 if the budget ran out.
    task automatic acquire(input bit toggle, output int nbits);
        nbits = -1;
        for (int i = 1; i <= 60; i++) begin
            send_gen(1'b0, 1'b0);
            @(posedge clk);
            #2;
            if (ifc.locked === 1'b1) begin
                nbits = i;
                break;
            end
            if (toggle) drive(1'b0, 1'($urandom), 1'b0);
        end
    endtask

    // Asserts reset between edges and checks that outputs clear at once.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_locked",    ifc.locked,    0);
        check("rst_err_pulse", ifc.err_pulse, 0);
        check("rst_err_count", ifc.err_count, 0);
        check("rst_bit_count", ifc.bit_count, 0);
        ifc.rx_valid     = 1'b0;
        ifc.rx_bit       = 1'b0;
        ifc.clear_counts = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- monitor ----------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_locked",    ifc.locked,    e.locked);
                check("sb_err_pulse", ifc.err_pulse, e.pulse);
                check("sb_err_count", ifc.err_count, e.errc);
                check("sb_bit_count", ifc.bit_count, e.bitc);
            end
        end
    end

    // ---------------- watchdog ---------------------------------------------
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ---------------------------------------------
    initial begin
        int nb;
        int burst;
        bit v;
        bit inv;
        bit clr;

        n_checks = 0;
        n_fail   = 0;
        gen_hist = {1'b1, 1'b0, 1'b0, 1'b1};
        model_reset();
        reset            = 1'b0;
        ifc.rx_valid     = 1'b0;
        ifc.rx_bit       = 1'b0;
        ifc.clear_counts = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_locked",    ifc.locked,    0);
        check("reset_err_count", ifc.err_count, 0);
        check("reset_bit_count", ifc.bit_count, 0);
        reset = 1'b1;

        // All-zero line: never leaves acquisition.
        repeat (40) drive(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("zeros_locked",    ifc.locked,    0);
        check("zeros_err_count", ifc.err_count, 0);

        // Lock from seed 1001 with continuous valid data.
        acquire(1'b0, nb);
        check("lock_latency", nb, N + LOCK_CNT);
        repeat (6) send_gen(1'b0, 1'b0);

        // Single inverted bit while locked.
        send_gen(1'b0, 1'b1);
        send_gen(1'b1, 1'b0);
        repeat (5) send_gen(1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("single_err_count", ifc.err_count, 1);
        check("single_locked",    ifc.locked,    1);

        // Four consecutive errors drop lock; clean data re-locks.
        send_gen(1'b0, 1'b1);
        repeat (LOSS_THRESH) send_gen(1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("loss_locked",    ifc.locked,    0);
        check("loss_err_count", ifc.err_count, LOSS_THRESH);
        acquire(1'b0, nb);
        check("relock_latency", nb, N + LOCK_CNT);

        // Isolated errors drive err_count into saturation without losing lock.
        for (int i = 0; i < 20; i++) begin
            send_gen(1'b1, 1'b0);
            send_gen(1'b0, 1'b0);
        end
        @(posedge clk);
        #2;
        check("sat_err_count", ifc.err_count, CNT_MAX);
        check("sat_locked",    ifc.locked,    1);

        // Clear coincident with an error.
        send_gen(1'b1, 1'b1);
        @(posedge clk);
        #2;
        check("clr_err_pulse", ifc.err_pulse, 1);
        check("clr_err_count", ifc.err_count, 0);
        check("clr_bit_count", ifc.bit_count, 0);

        // Randomised traffic: gaps, sparse errors, error bursts, clears.
        burst = 0;
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (!v) begin
                drive(1'b0, 1'($urandom), 1'b0);
            end else begin
                if (burst == 0 && $urandom_range(0, 199) == 0) burst = LOSS_THRESH;
                inv = (burst > 0) || ($urandom_range(0, 19) == 0);
                if (burst > 0) burst--;
                clr = ($urandom_range(0, 49) == 0);
                send_gen(inv, clr);
            end
        end

        // Reset mid-lock, then re-acquire.
        apply_reset();
        acquire(1'b0, nb);
        check("post_reset_latency", nb, N + LOCK_CNT);
        repeat (4) send_gen(1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_reset_locked", ifc.locked, 1);
        apply_reset();

        // Lock acquisition with valid toggling: counts valid bits, not cycles.
        acquire(1'b1, nb);
        check("toggle_latency", nb, N + LOCK_CNT);
        repeat (8) begin
            send_gen(1'b0, 1'b0);
            drive(1'b0, 1'($urandom), 1'b0);
        end

        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
